// File: rtl/fft32_sink_if.sv
// rtl/fft32_sink_if.sv - FFT32-side input stream and valid/ready output stream of fft32_sink
interface fft32_sink_if #(
  parameter int OUT_width = 16
);
  logic                        in_valid;
  logic signed [OUT_width-1:0] din_r;
  logic signed [OUT_width-1:0] din_i;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_width-1:0] dout_r;
  logic signed [OUT_width-1:0] dout_i;
  logic [4:0]                  out_idx;
  logic                        out_last;

  modport master (
    output in_valid, din_r, din_i, out_ready,
    input  out_valid, dout_r, dout_i, out_idx, out_last
  );

  modport slave (
    input  in_valid, din_r, din_i, out_ready,
    output out_valid, dout_r, dout_i, out_idx, out_last
  );
endinterface

// File: rtl/fft32_sink.sv
// rtl/fft32_sink.sv - FFT32 output collector: ping-pong capture, natural-order replay, latency watchdog
// Define FFT32_SINK_BITREV_EN to store samples at bitrev5(wcnt), undoing FFT32's bit-reversed bin order.
module fft32_sink #(
  parameter int FFT_size      = 32,
  parameter int OUT_width     = 16,
  parameter int latency_limit = 68
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_sent,
  fft32_sink_if.slave s,
  output logic        overflow,
  output logic        timeout
);

  localparam int AW   = $clog2(FFT_size);
  localparam int DW   = 2 * OUT_width;
  localparam int WD_W = $clog2(latency_limit + 2);
  localparam logic [AW-1:0]   LAST_IDX = AW'(FFT_size - 1);
  localparam logic [WD_W-1:0] LIMIT    = WD_W'(latency_limit);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
  typedef enum logic {WD_IDLE, WD_ARMED} wd_state_t;

  logic [DW-1:0] mem [2*FFT_size];
  bank_state_t   bank_st  [2];
  bank_state_t   bank_nxt [2];
  logic          wbank;
  logic          rbank;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] waddr;
  logic          wr_en;
  logic          wr_done;
  logic          fire;
  logic          rd_done;
  logic          load;
  logic          load_bank;
  logic [AW-1:0] load_idx;

`ifdef FFT32_SINK_BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    for (int b = 0; b < AW; b++) begin
      bitrev[b] = a[AW-1-b];
    end
  endfunction

  assign waddr = bitrev(wcnt);
`else
  assign waddr = wcnt;
`endif

  // Banks are only written while not FULL and only read while FULL, so the two sides never share a bank.
  assign wr_en   = s.in_valid && (bank_st[wbank] != FULL);
  assign wr_done = wr_en && (wcnt == LAST_IDX);
  assign fire    = s.out_valid && s.out_ready;
  assign rd_done = fire && (s.out_idx == LAST_IDX);

  always_comb begin
    bank_nxt = bank_st;
    if (wr_en) begin
      if (wr_done) begin
        bank_nxt[wbank] = FULL;
      end else begin
        bank_nxt[wbank] = FILLING;
      end
    end
    if (rd_done) begin
      bank_nxt[rbank] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      overflow   <= 1'b0;
    end else begin
      bank_st <= bank_nxt;
      if (s.in_valid && !wr_en) begin
        overflow <= 1'b1;
      end
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wr_done) begin
          wbank <= ~wbank;
        end
      end
      if (rd_done) begin
        rbank <= ~rbank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wbank, waddr}] <= {s.din_r, s.din_i};
    end
  end

  // Pick the next sample for the output register; the last bin of a bank chains straight into the other bank.
  always_comb begin
    load      = 1'b0;
    load_bank = rbank;
    load_idx  = '0;
    if (fire && !rd_done) begin
      load     = 1'b1;
      load_idx = s.out_idx + 1'b1;
    end else if (rd_done) begin
      load_bank = ~rbank;
      load      = (bank_st[~rbank] == FULL);
    end else if (!s.out_valid) begin
      load = (bank_st[rbank] == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.dout_r    <= '0;
      s.dout_i    <= '0;
      s.out_idx   <= '0;
      s.out_last  <= 1'b0;
    end else if (load) begin
      s.out_valid           <= 1'b1;
      {s.dout_r, s.dout_i}  <= mem[{load_bank, load_idx}];
      s.out_idx             <= load_idx;
      s.out_last            <= (load_idx == LAST_IDX);
    end else if (fire) begin
      s.out_valid <= 1'b0;
    end
  end

  wd_state_t       wd_state;
  wd_state_t       wd_next;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_cnt_next;
  logic            wd_expire;

  // The limit is tested before in_valid so that a first sample one cycle past the limit still counts as late.
  always_comb begin
    wd_next     = wd_state;
    wd_cnt_next = wd_cnt;
    wd_expire   = 1'b0;
    if (frame_sent) begin
      wd_next     = WD_ARMED;
      wd_cnt_next = '0;
    end else if (wd_state == WD_ARMED) begin
      wd_cnt_next = wd_cnt + 1'b1;
      if (wd_cnt_next > LIMIT) begin
        wd_expire = 1'b1;
        wd_next   = WD_IDLE;
      end else if (s.in_valid) begin
        wd_next = WD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_state <= WD_IDLE;
      wd_cnt   <= '0;
      timeout  <= 1'b0;
    end else begin
      wd_state <= wd_next;
      wd_cnt   <= wd_cnt_next;
      if (wd_expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft32_sink.sv
// tb/tb_fft32_sink.sv - randomized self-checking bench for fft32_sink against a frame-level reference model
module tb_fft32_sink;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_sent = 1'b0;
  logic overflow;
  logic timeout;

  fft32_sink_if #(.OUT_width(W)) bus ();

  fft32_sink #(.FFT_size(32), .OUT_width(W), .latency_limit(68)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_sent (frame_sent),
    .s          (bus.slave),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sent_q[$];
  logic [31:0] got_d[$];
  int          got_idx[$];
  bit          got_last[$];

  // Arrival position whose sample must appear at output slot `bin`.
  function automatic int arrival_pos(input int bin);
`ifdef FFT32_SINK_BITREV_EN
    int r = 0;
    for (int b = 0; b < 5; b++) begin
      if (((bin >> b) & 1) == 1) r += 1 << (4 - b);
    end
    return r;
`else
    return bin;
`endif
  endfunction

  function automatic logic [31:0] expected_at(input int n);
    return sent_q[(n / 32) * 32 + arrival_pos(n % 32)];
  endfunction

  task automatic clear_got();
    got_d.delete();
    got_idx.delete();
    got_last.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.din_r = '0;
    bus.din_i = '0;
    bus.out_ready = 1'b0;
    frame_sent = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sent_q.delete();
    clear_got();
  endtask

  task automatic feed(input int n, input bit gaps, input bit ramp);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.din_r = ramp ? W'(k) : W'($urandom);
      bus.din_i = W'($urandom);
      sent_q.push_back({bus.din_r, bus.din_i});
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit rnd);
    int cyc = 0;
    while (got_d.size() < n && cyc < 4000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back({bus.dout_r, bus.dout_i});
        got_idx.push_back(int'(bus.out_idx));
        got_last.push_back(bus.out_last);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got_d.size() != n) begin
      errors++;
      $display("FAIL drain_count: got %0d samples, required %0d", got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_idx, bus.dout_r, bus.dout_i, overflow, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_held: outputs %h, required 0",
               {bus.out_valid, bus.out_last, bus.out_idx, bus.dout_r, bus.dout_i, overflow, timeout});
    end
    reset_dut();
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_idx, bus.dout_r, bus.dout_i, overflow, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_released: outputs %h, required 0",
               {bus.out_valid, bus.out_last, bus.out_idx, bus.dout_r, bus.dout_i, overflow, timeout});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    reset_dut();
    feed(32, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid %b after last-sample edge, required 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd0) begin
      errors++;
      $display("FAIL latency_first: out_valid %b idx %0d one edge later, required 1 and 0", bus.out_valid, bus.out_idx);
    end
    drain(32, 1'b0);
    for (int n = 0; n < got_d.size(); n++) begin
      logic [31:0] e = expected_at(n);
      checks++;
      if (got_d[n] !== e || got_idx[n] != n % 32 || got_last[n] !== (n % 32 == 31)) begin
        errors++;
        $display("FAIL single_frame[%0d]: data %h idx %0d last %0b, required %h %0d %0b",
                 n, got_d[n], got_idx[n], got_last[n], e, n % 32, n % 32 == 31);
      end
    end
  endtask

  task automatic test_gaps_random_ready();
    reset_dut();
    feed(32, 1'b1, 1'b0);
    drain(32, 1'b1);
    for (int n = 0; n < got_d.size(); n++) begin
      logic [31:0] e = expected_at(n);
      checks++;
      if (got_d[n] !== e || got_idx[n] != n % 32 || got_last[n] !== (n % 32 == 31)) begin
        errors++;
        $display("FAIL gaps_frame[%0d]: data %h idx %0d last %0b, required %h %0d %0b",
                 n, got_d[n], got_idx[n], got_last[n], e, n % 32, n % 32 == 31);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          cyc = 0;
    bit          hold = 1'b0;
    logic [31:0] held_d = '0;
    logic [4:0]  held_idx = '0;
    logic        held_last = 1'b0;
    reset_dut();
    feed(32, 1'b0, 1'b0);
    while (got_d.size() < 32 && cyc < 500) begin
      bus.out_ready = pat[cyc % 4];
      @(negedge clk);
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.dout_r, bus.dout_i} !== held_d ||
            bus.out_idx !== held_idx || bus.out_last !== held_last) begin
          errors++;
          $display("FAIL hold_stable: valid %b data %h idx %0d last %b, required 1 %h %0d %b",
                   bus.out_valid, {bus.dout_r, bus.dout_i}, bus.out_idx, bus.out_last, held_d, held_idx, held_last);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held_d = {bus.dout_r, bus.dout_i};
      held_idx = bus.out_idx;
      held_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back({bus.dout_r, bus.dout_i});
        got_idx.push_back(int'(bus.out_idx));
        got_last.push_back(bus.out_last);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got_d.size() != 32) begin
      errors++;
      $display("FAIL backpressure_count: got %0d samples, required 32", got_d.size());
    end
    for (int n = 0; n < got_d.size(); n++) begin
      logic [31:0] e = expected_at(n);
      checks++;
      if (got_d[n] !== e || got_idx[n] != n % 32) begin
        errors++;
        $display("FAIL backpressure[%0d]: data %h idx %0d, required %h %0d", n, got_d[n], got_idx[n], e, n % 32);
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    fork
      feed(64, 1'b0, 1'b0);
      drain(64, 1'b0);
    join
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow: overflow %b, required 0", overflow);
    end
    for (int n = 0; n < got_d.size(); n++) begin
      logic [31:0] e = expected_at(n);
      checks++;
      if (got_d[n] !== e || got_idx[n] != n % 32 || got_last[n] !== (n % 32 == 31)) begin
        errors++;
        $display("FAIL b2b[%0d]: data %h idx %0d last %0b, required %h %0d %0b",
                 n, got_d[n], got_idx[n], got_last[n], e, n % 32, n % 32 == 31);
      end
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    feed(64, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_two_frames: overflow %b, required 0", overflow);
    end
    @(posedge clk);
    #1;
    feed(1, 1'b0, 1'b0);
    void'(sent_q.pop_back());
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_third_frame: overflow %b, required 1", overflow);
    end
    @(posedge clk);
    #1;
    drain(64, 1'b0);
    feed(32, 1'b0, 1'b0);
    drain(96, 1'b0);
    for (int n = 0; n < got_d.size(); n++) begin
      logic [31:0] e = expected_at(n);
      checks++;
      if (got_d[n] !== e || got_idx[n] != n % 32) begin
        errors++;
        $display("FAIL overflow_data[%0d]: data %h idx %0d, required %h %0d", n, got_d[n], got_idx[n], e, n % 32);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: overflow %b, required 1", overflow);
    end
  endtask

  task automatic test_watchdog();
    int gaps[5] = '{68, 69, 30, 0, 0};
    gaps[3] = $urandom_range(60, 76);
    gaps[4] = $urandom_range(60, 76);
    foreach (gaps[j]) begin
      reset_dut();
      frame_sent = 1'b1;
      @(posedge clk);
      #1 frame_sent = 1'b0;
      repeat (gaps[j] - 1) @(posedge clk);
      #1 bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (timeout !== (gaps[j] > 68)) begin
        errors++;
        $display("FAIL watchdog_gap%0d: timeout %b, required %b", gaps[j], timeout, gaps[j] > 68);
      end
    end

    reset_dut();
    frame_sent = 1'b1;
    @(posedge clk);
    #1 frame_sent = 1'b0;
    repeat (68) @(posedge clk);
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_edge68: timeout %b, required 0", timeout);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_edge69: timeout %b, required 1", timeout);
    end

    reset_dut();
    frame_sent = 1'b1;
    @(posedge clk);
    #1 frame_sent = 1'b0;
    repeat (39) @(posedge clk);
    #1 frame_sent = 1'b1;
    @(posedge clk);
    #1 frame_sent = 1'b0;
    repeat (67) @(posedge clk);
    #1 bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_restart: timeout %b, required 0", timeout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe();
    reset_dut();
    feed(32, 1'b0, 1'b0);
    feed(20, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_idx, bus.dout_r, bus.dout_i, overflow, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_midframe: outputs %h, required 0",
               {bus.out_valid, bus.out_last, bus.out_idx, bus.dout_r, bus.dout_i, overflow, timeout});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    sent_q.delete();
    clear_got();
    feed(32, 1'b0, 1'b0);
    drain(32, 1'b1);
    for (int n = 0; n < got_d.size(); n++) begin
      logic [31:0] e = expected_at(n);
      checks++;
      if (got_d[n] !== e || got_idx[n] != n % 32 || got_last[n] !== (n % 32 == 31)) begin
        errors++;
        $display("FAIL after_reset[%0d]: data %h idx %0d last %0b, required %h %0d %0b",
                 n, got_d[n], got_idx[n], got_last[n], e, n % 32, n % 32 == 31);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.din_r = '0;
    bus.din_i = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_gaps_random_ready();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_watchdog();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at 2000000, required completion");
    $fatal(1, "bench stopped");
  end

endmodule
